btb_assoc: RTL
==============

Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer, successor to the direct-mapped BTB in the IF stage.
- Looks up the fetch PC combinationally and returns hit, predicted direction (2-bit saturating counter) and predicted target.
- Trained by EX/branch-resolution writes, using full tag compare, tree pseudo-LRU replacement, allocate-on-taken-only and a one-cycle global flush.

Parameters:
- PC_W, 64, instruction address width.
- SETS, 64, number of sets; power of two, ≥2.
- WAYS, 2, associativity; legal values 1, 2, 4.
- IDX_W, log2(SETS), index width (derived).
- TAG_W, PC_W-IDX_W-2, tag width (derived).

Ports:
- cpu_clk_50M  in  1  clock, rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- lookup_pc  in  PC_W  fetch PC to predict.
- btb_hit  out  1  a valid way in the indexed set matches the tag.
- btb_jump_ena  out  1  predict taken; counter bit[1] of the hit way.
- btb_prepc_o  out  PC_W  predicted target of the hit way.
- wr_req  in  1  training write, sampled at clock edge.
- wr_pc  in  PC_W  PC of the resolved branch.
- wr_target  in  PC_W  resolved target.
- wr_jump_state  in  1  1 = branch resolved taken.
- flush  in  1  invalidate all entries at next edge.

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
- Per entry state: valid, tag[TAG_W], target[PC_W], cnt[2].
- Per set state: PLRU bits (WAYS-1 bits; 0 bits when WAYS=1).
- Counter encoding: 00 strong-not, 01 weak-not, 10 weak-jump, 11 strong-jump; saturating ±1.
- Reset (cpu_rst_n=0, asynchronous): all valid, cnt and PLRU bits cleared. While reset is asserted, btb_hit, btb_jump_ena and btb_prepc_o are forced to 0 combinationally. Tag and target arrays need no reset.
- Lookup is combinational, zero latency.
  - Hit: btb_hit=1, btb_jump_ena=cnt[1], btb_prepc_o=target.
  - Miss: all three outputs are 0.
  - Multiple matching ways cannot occur by construction; if they do, the lowest way wins.
- Lookup never modifies any state, including PLRU.
- Update (wr_req=1 and flush=0 at a posedge), set selected by wr_pc:
  - Hit, taken: cnt=sat(cnt+1), target=wr_target, way marked MRU.
  - Hit, not taken: cnt=sat(cnt-1), target unchanged, way marked MRU.
  - Miss, taken: allocate a victim way and write valid=1, tag, target=wr_target, cnt=10; mark it MRU.
  - Miss, not taken: no state change.
- Victim selection: lowest-numbered invalid way; if none, the PLRU way.
- PLRU: WAYS=2 uses one bit pointing at the LRU way. WAYS=4 uses a 3-bit tree: root plus two leaves, each node pointing away from the most recently touched half.
- flush=1 at a posedge clears all valid bits and PLRU bits. Flush wins over a simultaneous wr_req, which is dropped.
- Same-cycle lookup and update to the same entry: the lookup returns pre-update state (no bypass). The new state is visible on the next cycle.
- Reset asserted mid-update: the update is lost and the state is cleared. After deassertion, the first edge operates normally.

Test Plan:
- Reset then lookup_pc=0x8000_0000 -> btb_hit=0, btb_jump_ena=0, btb_prepc_o=0. Assert cpu_rst_n=0 between edges while a hit is showing -> outputs drop to 0 immediately.
- wr_req: pc 0x8000_0000, target 0x8000_0040, taken -> next cycle lookup of 0x8000_0000 gives hit=1, jump_ena=1, prepc=0x8000_0040. Lookup of 0x8001_0000 (same index, different tag) -> hit=0.
- Counter walk on 0x8000_0000 from 10: N, N, T, T, T, T -> jump_ena after each: 0, 0, 0, 1, 1, 1; final cnt=11. A not-taken write with target 0x1234 leaves prepc=0x8000_0040.
- Miss not-taken write for 0x8000_0080 -> lookup still hit=0, no allocation.
- SETS=64, WAYS=2, same set 0:
  - Sequence: alloc A=0x8000_0000 (way0), alloc B=0x8000_0100 (way1), taken update A, alloc C=0x8000_0200.
  - Required: A hit, B miss, C hit with its target.
  - With WAYS=4: fill 4 tags, touch ways 0, 2, 1 -> next alloc evicts way3.
- Fill several sets, pulse flush=1 for one cycle with wr_req=1 (new PC 0x8000_0300, taken) -> all lookups miss next cycle, including 0x8000_0300.

Source files
------------

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with 2-bit direction counters.
//
// Ports:
//   cpu_clk_50M    in   clock, rising edge
//   cpu_rst_n      in   asynchronous active-low reset
//   lookup_pc      in   fetch PC to predict (combinational lookup)
//   btb_hit        out  a valid way in the indexed set matches the tag
//   btb_jump_ena   out  predict taken (counter bit[1] of the hit way)
//   btb_prepc_o    out  predicted target of the hit way
//   wr_req         in   training write, sampled at the clock edge
//   wr_pc          in   PC of the resolved branch
//   wr_target      in   resolved target
//   wr_jump_state  in   1 = branch resolved taken
//   flush          in   invalidate all entries at the next edge (drops wr_req)
module btb_assoc #(
    parameter int unsigned PC_W  = 64,
    parameter int unsigned SETS  = 64,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = PC_W - IDX_W - 2
) (
    input  logic            cpu_clk_50M,
    input  logic            cpu_rst_n,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            btb_hit,
    output logic            btb_jump_ena,
    output logic [PC_W-1:0] btb_prepc_o,
    input  logic            wr_req,
    input  logic [PC_W-1:0] wr_pc,
    input  logic [PC_W-1:0] wr_target,
    input  logic            wr_jump_state,
    input  logic            flush
);

    localparam int unsigned WayW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    // A single-way BTB keeps one dummy PLRU bit that is never consulted.
    localparam int unsigned PlruW = (WAYS > 1) ? WAYS - 1 : 1;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [1:0]       cnt_q   [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [PC_W-1:0]  tgt_q   [SETS][WAYS];
    logic [PlruW-1:0] plru_q  [SETS];

    // Low PC bits never take part in indexing or tag compare.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc[1:0], wr_pc[1:0]};

    // ---------------- Lookup ----------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [WayW-1:0]  lk_way;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        // First match wins, so the lowest way takes priority.
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WayW'(w);
            end
        end
    end

    always_comb begin
        btb_hit      = 1'b0;
        btb_jump_ena = 1'b0;
        btb_prepc_o  = '0;
        if (cpu_rst_n && lk_hit) begin
            btb_hit      = 1'b1;
            btb_jump_ena = cnt_q[lk_idx][lk_way][1];
            btb_prepc_o  = tgt_q[lk_idx][lk_way];
        end
    end

    // ---------------- Update ----------------
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic [WayW-1:0]  wr_hway;
    logic             inv_found;
    logic [WayW-1:0]  inv_way;
    logic [PlruW-1:0] plru_cur;
    logic [WayW-1:0]  plru_vict;
    logic [PlruW-1:0] plru_new;
    logic [WayW-1:0]  upd_way;
    logic             upd_en;
    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_new;

    assign wr_idx   = wr_pc[IDX_W+1:2];
    assign wr_tag   = wr_pc[PC_W-1:IDX_W+2];
    assign plru_cur = plru_q[wr_idx];

    always_comb begin
        wr_hit    = 1'b0;
        wr_hway   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!wr_hit && valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
                wr_hit  = 1'b1;
                wr_hway = WayW'(w);
            end
            if (!inv_found && !valid_q[wr_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WayW'(w);
            end
        end
    end

    // Tree PLRU: each node points at the less recently used side.
    // 4 ways: bit0 = root (0 left pair, 1 right pair), bit1 = ways 0/1, bit2 = ways 2/3.
    if (WAYS == 4) begin : g_plru4
        always_comb begin
            plru_vict = {plru_cur[0], plru_cur[0] ? plru_cur[2] : plru_cur[1]};
            plru_new  = plru_cur;
            plru_new[0] = ~upd_way[1];
            if (upd_way[1]) begin
                plru_new[2] = ~upd_way[0];
            end else begin
                plru_new[1] = ~upd_way[0];
            end
        end
    end else if (WAYS == 2) begin : g_plru2
        always_comb begin
            plru_vict = plru_cur[0];
            plru_new  = ~upd_way;
        end
    end else begin : g_plru1
        always_comb begin
            plru_vict = '0;
            plru_new  = '0;
        end
    end

    always_comb begin
        upd_way = wr_hit ? wr_hway : (inv_found ? inv_way : plru_vict);
        // Not-taken misses never allocate.
        upd_en  = wr_req && !flush && (wr_hit || wr_jump_state);
        cnt_cur = cnt_q[wr_idx][wr_hway];
        if (!wr_hit) begin
            cnt_new = 2'b10;
        end else if (wr_jump_state) begin
            cnt_new = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'd1;
        end else begin
            cnt_new = (cnt_cur == 2'b00) ? 2'b00 : cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    cnt_q[s][w] <= 2'b00;
                end
            end
        end else if (flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (upd_en) begin
            valid_q[wr_idx][upd_way] <= 1'b1;
            cnt_q[wr_idx][upd_way]   <= cnt_new;
            plru_q[wr_idx]           <= plru_new;
        end
    end

    // Tag and target carry no reset; valid bits gate their visibility.
    always_ff @(posedge cpu_clk_50M) begin
        if (upd_en) begin
            tag_q[wr_idx][upd_way] <= wr_tag;
            if (wr_jump_state) begin
                tgt_q[wr_idx][upd_way] <= wr_target;
            end
        end
    end

endmodule
